uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Serial command receiver for the Jsilicon core. It deserialises 8N1 UART bytes on `rx` and assembles each two-byte command into the operand/opcode fields the FSM consumes: `a`, `b`, `opcode`. It is the input-side counterpart of the existing UART transmitter, so the core can be driven over one serial pin instead of `ui_in`/`uio_in`.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per bit (10 MHz / 115200). Must be ≥ 4.
- `TIMEOUT_BITS`, default 20: bit-times allowed between command byte 0 and byte 1 before the pending byte 0 is dropped.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `byte_data`  out  8  last correctly framed byte.
- `byte_valid`  out  1  one-cycle pulse: `byte_data` updated.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high while a frame is being received.
- `a`  out  4  operand A, held until the next command.
- `b`  out  4  operand B, held until the next command.
- `opcode`  out  3  opcode, held until the next command.
- `cmd_valid`  out  1  one-cycle pulse: `a`/`b`/`opcode` updated.

## Operation
- `rx` passes through a 2-FF synchroniser. Both flops reset to 1. `rxs` is the synchroniser output.
- The receive FSM has four states: IDLE, START, DATA, STOP.
  - IDLE → START: `rxs` is 0 and was 1 in the previous cycle (falling edge). The bit counter is loaded.
  - START: wait H = CLKS_PER_BIT/2 (integer division), then sample. If the sample is 1, it was a false start: go to IDLE with no outputs. If it is 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles. Shift LSB first. After 8 samples, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles, then return to IDLE in the next cycle. Sample 1: `byte_data` ← shift register and pulse `byte_valid`. Sample 0: pulse `frame_err`; `byte_data` is unchanged.
- `busy` is 1 in START, DATA and STOP, and 0 in IDLE.
- The command assembler has two states, WAIT0 and WAIT1.
  - WAIT0 and a valid byte: latch byte[7:4] as pending A and byte[3:0] as pending B, then go to WAIT1.
  - WAIT1 and a valid byte: `a`, `b` ← pending values; `opcode` ← byte[2:0], with byte[7:3] ignored. Pulse `cmd_valid` and go to WAIT0.
  - `frame_err` in either state: go to WAIT0 and discard pending data. `a`/`b`/`opcode` are untouched.
- Inter-byte timeout:
  - A counter runs only in WAIT1 while the receive FSM is in IDLE. It clears on every start detect.
  - When it reaches TIMEOUT_BITS × CLKS_PER_BIT, the assembler goes to WAIT0 and pending data is dropped.
  - Expiry and start detect in the same cycle: the start detect wins and pending data is kept.
- No flow control. A byte always completes. A new start edge is accepted the cycle after STOP, so back-to-back frames with no idle gap are received.

## Timing
- Reset values:
  - `byte_data`, `a`, `b`, `opcode` = 0.
  - `byte_valid`, `frame_err`, `cmd_valid`, `busy` = 0.
  - FSM in IDLE, assembler in WAIT0, synchroniser = 1.
- Asserting reset mid-frame aborts the frame and drops pending data. It produces no pulses.
- After reset release, `rx` held low produces no start; a 1 → 0 transition on `rxs` is required.
- Latency, with t0 = first cycle `rxs` = 0 (2–3 clk after the `rx` edge):
  - start sample at t0+H;
  - data bit k (k = 0..7) sampled at t0+H+(k+1)·CLKS_PER_BIT;
  - stop sample at t0+H+9·CLKS_PER_BIT;
  - `byte_valid` or `frame_err` high at t0+H+9·CLKS_PER_BIT+1, for exactly one cycle.
- `cmd_valid` is high in the same cycle as the `byte_valid` of byte 1. `a`/`b`/`opcode` change in that same cycle.
- `byte_data` is stable from `byte_valid` until the next valid byte.

## Test plan
Bench uses CLKS_PER_BIT=8, TIMEOUT_BITS=4.
1. Send 0x35 then 0x02 with 2 idle bits between → two `byte_valid` pulses (0x35, then 0x02). With the second pulse, `cmd_valid` = 1 for one cycle, a=3, b=5, opcode=2. Stop-to-pulse timing checked against the Timing formula.
2. Pulse `rx` low for 2 cycles from idle → `busy` high for H cycles then low. No `byte_valid`, `frame_err` or `cmd_valid`.
3. Send 0xA7 with stop bit = 0 → one `frame_err` pulse and no `byte_valid`; `byte_data` unchanged. Then send 0x12, 0x05 → a=1, b=2, opcode=5.
4. Send 0x9C, idle 40 cycles (> 32), then 0x46, 0x03 → 0x9C is dropped. The command is a=4, b=6, opcode=3, with exactly one `cmd_valid`.
5. Assert `rst_n`=0 during data bit 4 of byte 1, then release → all outputs 0 and no pulses. A following clean pair 0xFF, 0x07 → a=15, b=15, opcode=7.
6. Send 0x21 and 0x06 back-to-back, with the start bit immediately after the stop bit → both bytes received. Command a=2, b=1, opcode=6.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// Serial command receiver: 8N1 UART deserialiser feeding a two-byte command assembler
// that produces the a/b/opcode fields for the core FSM.
module uart_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] opcode,
    output logic       cmd_valid
);

    localparam int unsigned HALF      = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_M1  = TMO_W'(TMO_LIMIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        ASM_WAIT0,
        ASM_WAIT1
    } asm_state_t;

    logic             rx_meta;
    logic             rxs;
    logic             rxs_d;
    logic [1:0]       sync_fill;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       byte_data_nxt;
    logic             byte_valid_nxt;
    logic             frame_err_nxt;
    logic             busy_nxt;

    asm_state_t       asm_state, asm_state_nxt;
    logic [3:0]       pend_a, pend_a_nxt;
    logic [3:0]       pend_b, pend_b_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [3:0]       a_nxt;
    logic [3:0]       b_nxt;
    logic [2:0]       opcode_nxt;
    logic             cmd_valid_nxt;

    logic             start_det_c;

    // Synchroniser; rxs_d only becomes 1 once rxs reflects a real rx sample,
    // so rx held low through reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            sync_fill <= 2'b00;
            rxs_d     <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            rxs_d     <= rxs & sync_fill[1];
        end
    end

    assign start_det_c = (rx_state == RX_IDLE) && !rxs && rxs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            asm_state  <= ASM_WAIT0;
            pend_a     <= '0;
            pend_b     <= '0;
            tmo_cnt    <= '0;
            a          <= '0;
            b          <= '0;
            opcode     <= '0;
            cmd_valid  <= 1'b0;
        end else begin
            rx_state   <= rx_state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            byte_data  <= byte_data_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
            busy       <= busy_nxt;
            asm_state  <= asm_state_nxt;
            pend_a     <= pend_a_nxt;
            pend_b     <= pend_b_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            a          <= a_nxt;
            b          <= b_nxt;
            opcode     <= opcode_nxt;
            cmd_valid  <= cmd_valid_nxt;
        end
    end

    // Receive FSM and command assembler next-state logic.
    always_comb begin
        rx_state_nxt   = rx_state;
        cnt_nxt        = cnt;
        bit_idx_nxt    = bit_idx;
        shreg_nxt      = shreg;
        byte_data_nxt  = byte_data;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        asm_state_nxt  = asm_state;
        pend_a_nxt     = pend_a;
        pend_b_nxt     = pend_b;
        tmo_cnt_nxt    = tmo_cnt;
        a_nxt          = a;
        b_nxt          = b;
        opcode_nxt     = opcode;
        cmd_valid_nxt  = 1'b0;

        unique case (rx_state)
            RX_IDLE: begin
                if (start_det_c) begin
                    rx_state_nxt = RX_START;
                    cnt_nxt      = '0;
                    bit_idx_nxt  = '0;
                end
            end
            RX_START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt      = '0;
                    rx_state_nxt = rxs ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rxs, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_nxt      = '0;
                    rx_state_nxt = RX_IDLE;
                    if (rxs) begin
                        byte_data_nxt  = shreg;
                        byte_valid_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase

        // Inter-byte timeout: only ticks while waiting for byte 1 on an idle line.
        if (start_det_c || asm_state == ASM_WAIT0) begin
            tmo_cnt_nxt = '0;
        end else if (rx_state == RX_IDLE) begin
            if (tmo_cnt == TMO_M1) begin
                asm_state_nxt = ASM_WAIT0;
                tmo_cnt_nxt   = '0;
            end else begin
                tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
            end
        end

        if (frame_err_nxt) begin
            asm_state_nxt = ASM_WAIT0;
        end else if (byte_valid_nxt) begin
            if (asm_state == ASM_WAIT0) begin
                pend_a_nxt    = shreg[7:4];
                pend_b_nxt    = shreg[3:0];
                asm_state_nxt = ASM_WAIT1;
            end else begin
                a_nxt         = pend_a;
                b_nxt         = pend_b;
                opcode_nxt    = shreg[2:0];
                cmd_valid_nxt = 1'b1;
                asm_state_nxt = ASM_WAIT0;
            end
        end

        busy_nxt = (rx_state_nxt != RX_IDLE);
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at CLKS_PER_BIT=8, TIMEOUT_BITS=4.
module tb_uart_cmd_rx;

    localparam int unsigned C = 8;
    // rx driven 1ns after posedge N: 2 sync cycles + 1, then H=4, 9 bit times.
    localparam int PULSE_LAT = 79;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic       busy;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opcode;
    logic       cmd_valid;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int bv_cnt = 0, fe_cnt = 0, cv_cnt = 0, cv_bv_cnt = 0, busy_cnt = 0;
    int last_bv_cyc = 0, last_fe_cyc = 0, last_start_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    logic [3:0] cmd_a = 4'h0, cmd_b = 4'h0;
    logic [2:0] cmd_op = 3'h0;
    int bv0, fe0, cv0, busy0;

    uart_cmd_rx #(
        .CLKS_PER_BIT(8),
        .TIMEOUT_BITS(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .cmd_valid (cmd_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid) begin
            bv_cnt++;
            last_byte   = byte_data;
            last_bv_cyc = cyc;
        end
        if (frame_err) begin
            fe_cnt++;
            last_fe_cyc = cyc;
        end
        if (cmd_valid) begin
            cv_cnt++;
            if (byte_valid) cv_bv_cnt++;
            cmd_a  = a;
            cmd_b  = b;
            cmd_op = opcode;
        end
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called right after a posedge; returns on the posedge ending the stop bit.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        #1 rx = 1'b0;
        last_start_cyc = cyc;
        repeat (C) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1 rx = d[k];
            repeat (C) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (C) @(posedge clk);
    endtask

    task automatic idle(input int n);
        #1 rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic snap();
        bv0   = bv_cnt;
        fe0   = fe_cnt;
        cv0   = cv_cnt;
        busy0 = busy_cnt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx    = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("rst_byte_data", 32'(byte_data), 32'h00);
        check("rst_abop", {20'h0, a, b, opcode, 1'b0}, 32'h0);
        check("rst_pulses", {29'h0, byte_valid, frame_err, cmd_valid}, 32'h0);
        check("low_no_start", 32'(busy_cnt), 32'd0);
        idle(20);

        // 1: 0x35 then 0x02
        snap();
        send_byte(8'h35, 1'b1);
        check("t1_byte0", 32'(last_byte), 32'h35);
        check("t1_latency", 32'(last_bv_cyc - last_start_cyc), 32'(PULSE_LAT));
        check("t1_no_cmd_yet", 32'(cv_cnt - cv0), 32'd0);
        idle(2 * C);
        send_byte(8'h02, 1'b1);
        check("t1_byte1", 32'(last_byte), 32'h02);
        check("t1_bv_count", 32'(bv_cnt - bv0), 32'd2);
        check("t1_cv_count", 32'(cv_cnt - cv0), 32'd1);
        check("t1_cv_with_bv", 32'(cv_bv_cnt), 32'(cv_cnt));
        check("t1_cmd", {21'h0, cmd_a, cmd_b, cmd_op}, {21'h0, 4'h3, 4'h5, 3'h2});

        // 2: 2-cycle glitch is a false start
        idle(2 * C);
        snap();
        #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        idle(20);
        check("t2_busy_cycles", 32'(busy_cnt - busy0), 32'd4);
        check("t2_no_pulses", 32'((bv_cnt - bv0) + (fe_cnt - fe0) + (cv_cnt - cv0)), 32'd0);

        // 3: framing error, then a good command
        idle(2 * C);
        snap();
        send_byte(8'hA7, 1'b0);
        check("t3_fe_count", 32'(fe_cnt - fe0), 32'd1);
        check("t3_no_bv", 32'(bv_cnt - bv0), 32'd0);
        check("t3_fe_latency", 32'(last_fe_cyc - last_start_cyc), 32'(PULSE_LAT));
        check("t3_byte_data_held", 32'(byte_data), 32'h02);
        idle(2 * C);
        send_byte(8'h12, 1'b1);
        idle(2 * C);
        send_byte(8'h05, 1'b1);
        check("t3_cmd", {21'h0, cmd_a, cmd_b, cmd_op}, {21'h0, 4'h1, 4'h2, 3'h5});

        // 4: timeout drops pending 0x9C
        idle(2 * C);
        snap();
        send_byte(8'h9C, 1'b1);
        idle(40);
        send_byte(8'h46, 1'b1);
        idle(2 * C);
        send_byte(8'h03, 1'b1);
        check("t4_cv_count", 32'(cv_cnt - cv0), 32'd1);
        check("t4_cmd", {21'h0, cmd_a, cmd_b, cmd_op}, {21'h0, 4'h4, 4'h6, 3'h3});
        check("t4_outputs", {21'h0, a, b, opcode}, {21'h0, 4'h4, 4'h6, 3'h3});

        // 5: reset during data bit 4 of byte 1
        idle(2 * C);
        send_byte(8'h58, 1'b1);
        idle(2 * C);
        snap();
        fork
            send_byte(8'h03, 1'b1);
            begin
                repeat (C + 4 * C + 4) @(posedge clk);
                #1 rst_n = 1'b0;
            end
        join
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("t5_no_pulses", 32'((bv_cnt - bv0) + (fe_cnt - fe0) + (cv_cnt - cv0)), 32'd0);
        check("t5_outputs_zero", {12'h0, byte_data, a, b, opcode, busy}, 32'h0);
        send_byte(8'hFF, 1'b1);
        idle(2 * C);
        send_byte(8'h07, 1'b1);
        check("t5_cmd", {21'h0, cmd_a, cmd_b, cmd_op}, {21'h0, 4'hF, 4'hF, 3'h7});

        // 6: back-to-back frames, no idle gap
        idle(2 * C);
        snap();
        send_byte(8'h21, 1'b1);
        send_byte(8'h06, 1'b1);
        check("t6_bv_count", 32'(bv_cnt - bv0), 32'd2);
        check("t6_cv_count", 32'(cv_cnt - cv0), 32'd1);
        check("t6_cmd", {21'h0, cmd_a, cmd_b, cmd_op}, {21'h0, 4'h2, 4'h1, 3'h6});
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
